// File: rtl/id_operand_hazard_unit.sv
// ID-stage operand resolution and load-use interlock with an instruction hold
// register, so a fetched SRAM word survives any number of stall cycles.
module id_operand_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int NUM_FWD   = 3,
  parameter int LOAD_LAT  = 1,
  parameter int STALL_MAX = 15,
  localparam int CW       = $clog2(STALL_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid,
  input  logic [31:0]             inst_in,
  input  logic [31:0]             pc_in,
  input  logic                    stall_in,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       rf_rdata1,
  input  logic [DATA_W-1:0]       rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_is_load,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  output logic [4:0]              rs_addr,
  output logic [4:0]              rt_addr,
  output logic [31:0]             inst_out,
  output logic [31:0]             pc_out,
  output logic                    valid_out,
  output logic [DATA_W-1:0]       op1,
  output logic [DATA_W-1:0]       op2,
  output logic                    stallreq,
  output logic [CW-1:0]           stall_cnt,
  output logic                    wdog_err,
  output logic                    state_dbg
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic [31:0]     hold_pc_q, hold_pc_d;
  logic            hold_v_q, hold_v_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            wdog_err_q, wdog_err_d;

  logic            cur_valid;
  logic            rs_hit, rt_hit, rs_ld, rt_ld;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic            stall_any;

  // Handshake: valid_out qualifies inst_out/op1/op2 in the same cycle; the ID
  // slot advances only on an edge where neither stall_in nor stallreq is high.
  always_comb begin
    inst_out = '0;
    pc_out   = '0;
    if (rst) begin
      inst_out = (state_q == HOLD) ? hold_inst_q : inst_in;
      pc_out   = (state_q == HOLD) ? hold_pc_q   : pc_in;
    end
    cur_valid = rst & ((state_q == HOLD) ? hold_v_q : inst_valid);
    rs_addr   = inst_out[25:21];
    rt_addr   = inst_out[20:16];
    state_dbg = (state_q == HOLD);
  end

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_ld  = 1'b0;
    rt_ld  = 1'b0;
    rs_fwd = '0;
    rt_fwd = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && fwd_addr[5*k +: 5] == rs_addr && rs_addr != 5'd0) begin
        rs_hit = 1'b1;
        rs_fwd = fwd_data[DATA_W*k +: DATA_W];
        rs_ld  = fwd_is_load[k] && (k < LOAD_LAT);
      end
      if (fwd_we[k] && fwd_addr[5*k +: 5] == rt_addr && rt_addr != 5'd0) begin
        rt_hit = 1'b1;
        rt_fwd = fwd_data[DATA_W*k +: DATA_W];
        rt_ld  = fwd_is_load[k] && (k < LOAD_LAT);
      end
    end
    op1 = (rs_addr == 5'd0) ? '0 : (rs_hit ? rs_fwd : rf_rdata1);
    op2 = (rt_addr == 5'd0) ? '0 : (rt_hit ? rt_fwd : rf_rdata2);
    stallreq  = cur_valid & ~flush & (rs_ld | rt_ld);
    valid_out = cur_valid & ~stallreq & ~flush;
    stall_any = stall_in | stallreq;
  end

  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    hold_v_d    = hold_v_q;
    case (state_q)
      RUN: begin
        if (stall_any && inst_valid && !flush) begin
          state_d     = HOLD;
          hold_inst_d = inst_in;
          hold_pc_d   = pc_in;
          hold_v_d    = 1'b1;
        end
      end
      HOLD: begin
        if (flush || !stall_any) begin
          state_d  = RUN;
          hold_v_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = '0;
    if (!flush && cur_valid && stall_any) begin
      stall_cnt_d = (stall_cnt_q == CW'(STALL_MAX)) ? stall_cnt_q : stall_cnt_q + CW'(1);
    end
    wdog_err_d = wdog_err_q | (stall_cnt_d == CW'(STALL_MAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      hold_v_q    <= 1'b0;
      stall_cnt_q <= '0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_v_q    <= hold_v_d;
      stall_cnt_q <= stall_cnt_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_id_operand_hazard_unit.sv
// Directed bench for id_operand_hazard_unit: two instances (LOAD_LAT 1 and 2)
// share stimulus; every expected value below is hand-computed.
module tb_id_operand_hazard_unit;

  localparam int DW = 32;
  localparam int NF = 3;

  logic          clk, rst;
  logic          inst_valid, stall_in, flush;
  logic [31:0]   inst_in, pc_in;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [NF-1:0] fwd_we, fwd_is_load;
  logic [5*NF-1:0]  fwd_addr;
  logic [DW*NF-1:0] fwd_data;

  logic [4:0]    rs_addr_a, rt_addr_a, rs_addr_b, rt_addr_b;
  logic [31:0]   inst_out_a, pc_out_a, inst_out_b, pc_out_b;
  logic          valid_a, valid_b, stallreq_a, stallreq_b;
  logic [DW-1:0] op1_a, op2_a, op1_b, op2_b;
  logic [3:0]    cnt_a, cnt_b;
  logic          wdog_a, wdog_b, st_a, st_b;

  int n_vec = 0;
  int n_err = 0;

  id_operand_hazard_unit #(.LOAD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_in(inst_in), .pc_in(pc_in),
    .stall_in(stall_in), .flush(flush), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rs_addr(rs_addr_a), .rt_addr(rt_addr_a), .inst_out(inst_out_a), .pc_out(pc_out_a),
    .valid_out(valid_a), .op1(op1_a), .op2(op2_a), .stallreq(stallreq_a),
    .stall_cnt(cnt_a), .wdog_err(wdog_a), .state_dbg(st_a)
  );

  id_operand_hazard_unit #(.LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_in(inst_in), .pc_in(pc_in),
    .stall_in(stall_in), .flush(flush), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rs_addr(rs_addr_b), .rt_addr(rt_addr_b), .inst_out(inst_out_b), .pc_out(pc_out_b),
    .valid_out(valid_b), .op1(op1_b), .op2(op2_b), .stallreq(stallreq_b),
    .stall_cnt(cnt_b), .wdog_err(wdog_b), .state_dbg(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_src();
    fwd_we      = '0;
    fwd_is_load = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
  endtask

  task automatic set_src(input int k, input logic ld, input logic [4:0] a, input logic [31:0] d);
    fwd_we[k]          = 1'b1;
    fwd_is_load[k]     = ld;
    fwd_addr[5*k +: 5] = a;
    fwd_data[DW*k +: DW] = d;
  endtask

  task automatic set_inst(input logic v, input logic [31:0] i, input logic [31:0] p);
    inst_valid = v;
    inst_in    = i;
    pc_in      = p;
  endtask

  initial begin
    rst = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    rf_rdata1 = 32'h1111_1111;
    rf_rdata2 = 32'h2222_2222;
    clr_src();
    set_inst(1'b1, 32'hDEAD_BEEF, 32'h0000_0040);
    #2;
    // reset forces zero outputs even with live inputs
    check("rst_inst", inst_out_a, 32'h0);
    check("rst_pc", pc_out_a, 32'h0);
    check("rst_valid", valid_a, 0);
    check("rst_op1", op1_a, 32'h0);
    check("rst_cnt", cnt_a, 0);
    @(negedge clk);
    rst = 1'b1;
    set_inst(1'b0, 32'h0, 32'h0);
    tick();

    // load-use: src0 load to r5, addu r3,r5,r6
    set_inst(1'b1, 32'h00A6_1821, 32'h0000_0100);
    set_src(0, 1'b1, 5'd5, 32'h5555_0000);
    #1;
    check("lu_rs_addr", rs_addr_a, 5);
    check("lu_stallreq", stallreq_a, 1);
    check("lu_valid", valid_a, 0);
    tick();
    set_inst(1'b1, 32'hAAAA_AAAA, 32'h0000_0104);
    clr_src();
    set_src(1, 1'b0, 5'd5, 32'h0000_1234);
    #1;
    check("lu_held_inst", inst_out_a, 32'h00A6_1821);
    check("lu_held_pc", pc_out_a, 32'h0000_0100);
    check("lu_state_hold", st_a, 1);
    check("lu_stallreq_rel", stallreq_a, 0);
    check("lu_op1_fwd", op1_a, 32'h0000_1234);
    check("lu_op2_rf", op2_a, 32'h2222_2222);
    check("lu_valid_rel", valid_a, 1);
    check("lu_cnt_1", cnt_a, 1);
    tick();
    check("lu_cnt_0", cnt_a, 0);
    check("lu_state_run", st_a, 0);
    check("lu_next_inst", inst_out_a, 32'hAAAA_AAAA);

    // priority: all three write r7
    clr_src();
    set_inst(1'b1, 32'h0007_0000, 32'h0000_0200);
    set_src(0, 1'b0, 5'd7, 32'hA);
    set_src(1, 1'b0, 5'd7, 32'hB);
    set_src(2, 1'b0, 5'd7, 32'hC);
    #1;
    check("pri_op2_src0", op2_a, 32'hA);
    check("pri_op1_r0", op1_a, 32'h0);
    fwd_addr[4:0] = 5'd0;
    #1;
    check("pri_r0_noshadow", op2_a, 32'hB);
    clr_src();
    #1;
    check("pri_rf", op2_a, 32'h2222_2222);
    set_inst(1'b1, 32'h0000_0000, 32'h0000_0204);
    set_src(0, 1'b1, 5'd0, 32'h77);
    #1;
    check("pri_r0_op2", op2_a, 32'h0);
    check("pri_r0_nostall", stallreq_a, 0);
    clr_src();
    tick();

    // hold across stall_in
    set_inst(1'b1, 32'h3C01_0001, 32'h0000_0300);
    stall_in = 1'b1;
    tick();
    set_inst(1'b1, 32'hFFFF_FFFF, 32'h0000_0304);
    tick();
    tick();
    check("hold_inst", inst_out_a, 32'h3C01_0001);
    check("hold_pc", pc_out_a, 32'h0000_0300);
    check("hold_rt", rt_addr_a, 1);
    check("hold_cnt3", cnt_a, 3);
    stall_in = 1'b0;
    #1;
    check("hold_rel_inst", inst_out_a, 32'h3C01_0001);
    check("hold_rel_valid", valid_a, 1);
    tick();
    check("hold_consumed", inst_out_a, 32'hFFFF_FFFF);
    check("hold_cnt0", cnt_a, 0);

    // LOAD_LAT: load in src1 to rt
    set_inst(1'b1, 32'h0009_0000, 32'h0000_0400);
    set_src(1, 1'b1, 5'd9, 32'h99);
    #1;
    check("ll1_nostall", stallreq_a, 0);
    check("ll1_op2", op2_a, 32'h99);
    check("ll1_valid", valid_a, 1);
    check("ll2_stall", stallreq_b, 1);
    check("ll2_valid", valid_b, 0);
    set_src(0, 1'b0, 5'd9, 32'h77);
    #1;
    check("ll2_shadow_nostall", stallreq_b, 0);
    check("ll2_shadow_op2", op2_b, 32'h77);
    clr_src();
    set_inst(1'b0, 32'h0, 32'h0);
    tick();

    // flush during HOLD with stallreq
    set_inst(1'b1, 32'h00A6_1821, 32'h0000_0500);
    set_src(0, 1'b1, 5'd5, 32'h0);
    tick();
    set_inst(1'b0, 32'h0, 32'h0);
    #1;
    check("fl_hold", st_a, 1);
    check("fl_stall_before", stallreq_a, 1);
    flush = 1'b1;
    #1;
    check("fl_stallreq", stallreq_a, 0);
    check("fl_valid", valid_a, 0);
    tick();
    flush = 1'b0;
    clr_src();
    #1;
    check("fl_run", st_a, 0);
    check("fl_cnt", cnt_a, 0);

    // watchdog
    set_inst(1'b1, 32'h0000_0000, 32'h0000_0600);
    stall_in = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("wd_cnt14", cnt_a, 14);
    check("wd_not_yet", wdog_a, 0);
    tick();
    check("wd_cnt15", cnt_a, 15);
    check("wd_set", wdog_a, 1);
    tick();
    check("wd_sat", cnt_a, 15);
    stall_in = 1'b0;
    tick();
    check("wd_cnt_clr", cnt_a, 0);
    check("wd_sticky", wdog_a, 1);

    // reset mid-HOLD
    set_inst(1'b1, 32'h1234_5678, 32'h0000_0700);
    stall_in = 1'b1;
    tick();
    check("r_hold", st_a, 1);
    #2;
    rst = 1'b0;
    #1;
    check("r_inst", inst_out_a, 32'h0);
    check("r_pc", pc_out_a, 32'h0);
    check("r_valid", valid_a, 0);
    check("r_stallreq", stallreq_a, 0);
    check("r_cnt", cnt_a, 0);
    check("r_wdog", wdog_a, 0);
    check("r_state", st_a, 0);
    stall_in = 1'b0;
    set_inst(1'b1, 32'h0BAD_F00D, 32'h0000_0800);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("r_run_inst", inst_out_a, 32'h0BAD_F00D);
    check("r_run_valid", valid_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
